alu_channel_scheduler: RTL and testbench

Sequences the single shared convolution ALU between the left and right channels once per input sample. The block starts a clear/run pass for L, then for R, and captures each 40-bit accumulator result. It then issues one P2S load with both results valid. It sits between Control (enable, sample strobes) and the ALU/P2S path, and reports overrun and timeout faults.

---
 rtl/alu_channel_scheduler.sv | 131 +++++++++++++
 tb/tb_alu_channel_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_channel_scheduler.sv
// Sequences the shared convolution ALU over the left then right channel per sample
// and hands both results to P2S. Optional macro: SCHED_ZERO_SKIP_EN (zero-run bypass).
module alu_channel_scheduler #(
  parameter int ACC_W   = 40,
  parameter int TIMEOUT = 600,
  parameter int TO_W    = 10
) (
  input  logic             SCLK,
  input  logic             Reset_n,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic             alu_done,
  input  logic [ACC_W-1:0] alu_accum,
  input  logic             all_zeros,
  input  logic             clr_flags,
  output logic             alu_clear,
  output logic             alu_en,
  output logic             alu_sel,
  output logic [ACC_W-1:0] out_l,
  output logic [ACC_W-1:0] out_r,
  output logic             out_valid,
  output logic             p2s_load,
  output logic             busy,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic [2:0] {IDLE, CLR_L, RUN_L, CLR_R, RUN_R, LOAD} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] watchdog;
  logic            wd_limit;
  logic            running;
  logic            start;
  logic            zero_start;
  logic            set_ovr;
  logic            set_to;

  assign wd_limit = (watchdog == TO_W'(TIMEOUT - 1));
  assign running  = (state == RUN_L) || (state == RUN_R);
  assign start    = sample_valid && enable && ((state == IDLE) || (state == LOAD));
  assign set_ovr  = sample_valid && enable &&
                    ((state == CLR_L) || (state == RUN_L) || (state == CLR_R) || (state == RUN_R));
  // Done and watchdog limit in the same cycle resolve as done.
  assign set_to   = running && enable && wd_limit && !alu_done;

`ifdef SCHED_ZERO_SKIP_EN
  assign zero_start = start && all_zeros;
`else
  logic zero_skip_unused;
  assign zero_skip_unused = all_zeros;
  assign zero_start       = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    alu_clear = 1'b0;
    alu_en    = 1'b0;
    alu_sel   = 1'b0;
    out_valid = 1'b0;
    p2s_load  = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) state_nxt = zero_start ? LOAD : CLR_L;
      end
      CLR_L: begin
        alu_clear = 1'b1;
        state_nxt = RUN_L;
      end
      RUN_L: begin
        alu_en = 1'b1;
        if (alu_done || wd_limit) state_nxt = CLR_R;
      end
      CLR_R: begin
        alu_clear = 1'b1;
        alu_sel   = 1'b1;
        state_nxt = RUN_R;
      end
      RUN_R: begin
        alu_en  = 1'b1;
        alu_sel = 1'b1;
        if (alu_done || wd_limit) state_nxt = LOAD;
      end
      LOAD: begin
        out_valid = 1'b1;
        p2s_load  = 1'b1;
        alu_sel   = 1'b1;
        if (start) state_nxt = zero_start ? LOAD : CLR_L;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Dropping enable abandons the pass without a load.
    if ((state != IDLE) && !enable) state_nxt = IDLE;
  end

  always_ff @(posedge SCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      watchdog <= '0;
      out_l    <= '0;
      out_r    <= '0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == CLR_L) || (state == CLR_R)) watchdog <= '0;
      else if (running)                         watchdog <= watchdog + 1'b1;

      if (zero_start) begin
        out_l <= '0;
        out_r <= '0;
      end else if (enable && (state == RUN_L)) begin
        if (alu_done)      out_l <= alu_accum;
        else if (wd_limit) out_l <= '0;
      end else if (enable && (state == RUN_R)) begin
        if (alu_done)      out_r <= alu_accum;
        else if (wd_limit) out_r <= '0;
      end

      if (set_ovr)        overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;

      if (set_to)         timeout <= 1'b1;
      else if (clr_flags) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_channel_scheduler.sv
// Randomized self-checking bench for alu_channel_scheduler; the reference model derives
// each pass as a timeline of cycle numbers from the chosen ALU done delays.
module tb_alu_channel_scheduler;

  localparam int ACC_W = 40;
  localparam int TO    = 16;

  logic             SCLK = 1'b0;
  logic             Reset_n;
  logic             enable, sample_valid, alu_done, all_zeros, clr_flags;
  logic [ACC_W-1:0] alu_accum;
  logic             alu_clear, alu_en, alu_sel, out_valid, p2s_load, busy, overrun, timeout;
  logic [ACC_W-1:0] out_l, out_r;

  always #5 SCLK = ~SCLK;

  alu_channel_scheduler #(.ACC_W(ACC_W), .TIMEOUT(TO), .TO_W(10)) dut (
    .SCLK(SCLK), .Reset_n(Reset_n), .enable(enable), .sample_valid(sample_valid),
    .alu_done(alu_done), .alu_accum(alu_accum), .all_zeros(all_zeros), .clr_flags(clr_flags),
    .alu_clear(alu_clear), .alu_en(alu_en), .alu_sel(alu_sel), .out_l(out_l), .out_r(out_r),
    .out_valid(out_valid), .p2s_load(p2s_load), .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  int vectors = 0;
  int miscompares = 0;
  int t = 0;

  // Reference model: one active pass, described by its start cycle and per-channel done delays
  // (delay > TO means the ALU never answers). Phase codes: 0 idle, 1 clrL, 2 runL, 3 clrR, 4 runR, 5 load.
  bit               active = 0;
  bit               skip = 0;
  int               s = 0, dl = 1, dr = 1;
  int               force_dl = -1, force_dr = -1;
  bit               use_force_acc = 0;
  logic [ACC_W-1:0] force_acc_l = '0, force_acc_r = '0;
  logic [ACC_W-1:0] acc_l = '0, acc_r = '0, exp_l = '0, exp_r = '0;
  bit               exp_ov = 0, exp_to = 0;

  function automatic int endL();
    return s + 1 + ((dl <= TO) ? dl : TO);
  endfunction

  function automatic int endR();
    return endL() + 1 + ((dr <= TO) ? dr : TO);
  endfunction

  function automatic int phaseAt(input int c);
    if (!active) return 0;
    if (skip) return (c == s + 1) ? 5 : 0;
    if (c == s + 1) return 1;
    if (c <= endL()) return 2;
    if (c == endL() + 1) return 3;
    if (c <= endR()) return 4;
    if (c == endR() + 1) return 5;
    return 0;
  endfunction

  function automatic logic [ACC_W-1:0] randAcc();
    return ACC_W'({$urandom(), $urandom()});
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_clear"}, 64'(alu_clear), 64'(0));
    checkOutput({tag, "_en"}, 64'(alu_en), 64'(0));
    checkOutput({tag, "_sel"}, 64'(alu_sel), 64'(0));
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'(0));
    checkOutput({tag, "_load"}, 64'(p2s_load), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_out_l"}, 64'(out_l), 64'(0));
    checkOutput({tag, "_out_r"}, 64'(out_r), 64'(0));
    checkOutput({tag, "_ovr"}, 64'(overrun), 64'(0));
    checkOutput({tag, "_to"}, 64'(timeout), 64'(0));
  endtask

  task automatic modelReset();
    active = 0;
    skip   = 0;
    exp_l  = '0;
    exp_r  = '0;
    exp_ov = 0;
    exp_to = 0;
  endtask

  task automatic startPass(input int c, input bit az);
    active = 1;
    skip   = 0;
    s      = c;
    dl     = (force_dl > 0) ? force_dl : $urandom_range(1, TO + 4);
    dr     = (force_dr > 0) ? force_dr : $urandom_range(1, TO + 4);
    acc_l  = use_force_acc ? force_acc_l : randAcc();
    acc_r  = use_force_acc ? force_acc_r : randAcc();
`ifdef SCHED_ZERO_SKIP_EN
    if (az) begin
      skip  = 1;
      exp_l = '0;
      exp_r = '0;
    end
`else
    if (az) skip = 0;
`endif
  endtask

  task automatic modelEdge(input int ph, input bit sv, input bit en, input bit az, input bit clr);
    bit set_to;
    set_to = 0;
    if (en && ph == 2 && t == endL()) begin
      exp_l  = (dl <= TO) ? acc_l : '0;
      set_to = (dl > TO);
    end
    if (en && ph == 4 && t == endR()) begin
      exp_r  = (dr <= TO) ? acc_r : '0;
      set_to = (dr > TO);
    end
    if (clr) begin
      exp_ov = 0;
      exp_to = 0;
    end
    if (sv && en && ph >= 1 && ph <= 4) exp_ov = 1;
    if (set_to) exp_to = 1;
    if (ph != 0 && !en)                       active = 0;
    else if ((ph == 0 || ph == 5) && sv && en) startPass(t, az);
    else if (ph == 5)                         active = 0;
  endtask

  // Drives one cycle (entered just after a rising edge), checks at the falling edge,
  // then advances the model across the next rising edge.
  task automatic applyStimulus(input bit sv, input bit en, input bit az, input bit clr);
    int               ph;
    bit               dn;
    logic [ACC_W-1:0] acc;
    ph  = phaseAt(t);
    dn  = 0;
    acc = randAcc();
    if (ph == 2 && dl <= TO && t == endL()) begin
      dn  = 1;
      acc = acc_l;
    end else if (ph == 4 && dr <= TO && t == endR()) begin
      dn  = 1;
      acc = acc_r;
    end else if (ph != 2 && ph != 4) begin
      dn = ($urandom_range(0, 7) == 0);
    end
    sample_valid = sv;
    enable       = en;
    all_zeros    = az;
    clr_flags    = clr;
    alu_done     = dn;
    alu_accum    = acc;
    @(negedge SCLK);
    checkOutput("alu_clear", 64'(alu_clear), 64'(ph == 1 || ph == 3));
    checkOutput("alu_en", 64'(alu_en), 64'(ph == 2 || ph == 4));
    checkOutput("alu_sel", 64'(alu_sel), 64'(ph >= 3));
    checkOutput("out_valid", 64'(out_valid), 64'(ph == 5));
    checkOutput("p2s_load", 64'(p2s_load), 64'(ph == 5));
    checkOutput("busy", 64'(busy), 64'(ph != 0));
    checkOutput("out_l", 64'(out_l), 64'(exp_l));
    checkOutput("out_r", 64'(out_r), 64'(exp_r));
    checkOutput("overrun", 64'(overrun), 64'(exp_ov));
    checkOutput("timeout", 64'(timeout), 64'(exp_to));
    @(posedge SCLK);
    modelEdge(ph, sv, en, az, clr);
    t++;
    #1;
  endtask

  task automatic waitPhase(input int target);
    int guard;
    guard = 0;
    while (phaseAt(t) != target && guard < 100) begin
      applyStimulus(0, 1, 0, 0);
      guard++;
    end
    if (phaseAt(t) != target) checkOutput("wait_phase", 64'(phaseAt(t)), 64'(target));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit at cycle %0d", t);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    Reset_n = 1'b0;
    {enable, sample_valid, alu_done, all_zeros, clr_flags} = '0;
    alu_accum = '0;
    modelReset();
    #3;
    checkAllZero("rst");
    @(negedge SCLK);
    Reset_n = 1'b1;
    @(posedge SCLK);
    #1;

    // Nominal pass, done in the fifth run cycle of each channel
    $display("[TB] nominal pass");
    force_dl = 5; force_dr = 5; use_force_acc = 1;
    force_acc_l = 40'h00_0000_1234; force_acc_r = 40'hFF_FFFF_FF00;
    applyStimulus(1, 1, 0, 0);
    waitPhase(5);
    applyStimulus(0, 1, 0, 0);
    checkOutput("nom_out_l", 64'(out_l), 64'h1234);
    checkOutput("nom_out_r", 64'(out_r), 64'hFF_FFFF_FF00);

    // ALU never answers: both channels time out
    $display("[TB] timeout pass");
    force_dl = TO + 10; force_dr = TO + 10;
    applyStimulus(1, 1, 0, 0);
    waitPhase(5);
    applyStimulus(0, 1, 0, 0);
    checkOutput("to_out_l", 64'(out_l), 64'(0));
    checkOutput("to_flag", 64'(timeout), 64'(1));
    applyStimulus(0, 1, 0, 1);
    checkOutput("to_cleared", 64'(timeout), 64'(0));
    force_dl = -1; force_dr = -1; use_force_acc = 0;

    // Overrun in RUN_R, then back-to-back sample in LOAD
    $display("[TB] overrun and back-to-back");
    applyStimulus(1, 1, 0, 0);
    waitPhase(4);
    applyStimulus(1, 1, 0, 0);
    checkOutput("ovr_set", 64'(overrun), 64'(1));
    waitPhase(5);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(1, 1, 0, 0);
    waitPhase(5);
    applyStimulus(1, 1, 0, 0);
    checkOutput("b2b_clear", 64'(alu_clear), 64'(1));
    checkOutput("b2b_ovr", 64'(overrun), 64'(0));
    waitPhase(5);
    applyStimulus(0, 1, 0, 0);

    // Abort by dropping enable in RUN_L; samples while disabled are ignored
    $display("[TB] abort");
    applyStimulus(1, 1, 0, 0);
    waitPhase(2);
    applyStimulus(0, 0, 0, 0);
    checkOutput("abort_busy", 64'(busy), 64'(0));
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);

    // Asynchronous reset in the middle of RUN_R
    $display("[TB] async reset mid-pass");
    applyStimulus(1, 1, 0, 0);
    waitPhase(4);
    {sample_valid, alu_done, clr_flags} = '0;
    #2;
    Reset_n = 1'b0;
    #1;
    checkAllZero("midrst");
    modelReset();
    @(negedge SCLK);
    Reset_n = 1'b1;
    @(posedge SCLK);
    #1;
    t++;
    applyStimulus(1, 1, 0, 0);
    waitPhase(5);
    applyStimulus(0, 1, 0, 0);

    // all_zeros sample: bypass with the macro, full pass without
    $display("[TB] zero-run sample");
    applyStimulus(1, 1, 1, 0);
    waitPhase(5);
    applyStimulus(0, 1, 0, 0);
`ifdef SCHED_ZERO_SKIP_EN
    checkOutput("zs_out_l", 64'(out_l), 64'(0));
    checkOutput("zs_out_r", 64'(out_r), 64'(0));
`endif

    // Randomized traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 39) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
